// File: rtl/mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit: single-transaction Avalon-MM data-memory master with
// lane placement, load extraction and a waitrequest timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic [31:0] load_data_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;
  localparam logic [1:0] c_ERR    = 2'd3;

  logic [1:0]  r_state, w_next;
  logic        r_is_load, r_signed, r_bus_err;
  logic [1:0]  r_size, r_offset;
  logic [31:0] r_wait_cnt;
  logic        w_misaligned, w_accept, w_timeout;
  logic [31:0] w_wdata, w_load_ext;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept     = (r_state == c_IDLE) && start_i;
  assign w_misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                        ((size_i == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                        (size_i == 2'b11);
  // Fires on the stalled cycle that would make the count reach WAIT_LIMIT.
  assign w_timeout    = (WAIT_LIMIT != 0) && avm_waitrequest_i &&
                        (r_wait_cnt == WAIT_LIMIT - 1);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_state <= c_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (start_i) w_next = w_misaligned ? c_ERR : c_ACCESS;
      c_ACCESS: if (!avm_waitrequest_i || w_timeout) w_next = c_DONE;
      c_DONE:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (r_state != c_IDLE);
    done_o       = (r_state == c_DONE) || (r_state == c_ERR);
    misaligned_o = (r_state == c_ERR);
    bus_error_o  = (r_state == c_DONE) && r_bus_err;
    avm_read_o   = (r_state == c_ACCESS) && r_is_load;
    avm_write_o  = (r_state == c_ACCESS) && !r_is_load;
  end

  // Lane placement from the top-aligned store data and the low address bits.
  always_comb begin
    w_wdata = store_data_i;
    w_be    = 4'b1111;
    case (size_i)
      2'b00: begin
        w_wdata = {4{store_data_i[31:24]}};
        w_be    = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data_i[31:16]}};
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = avm_readdata_i[7:0];
    case (r_offset)
      2'b01:   w_byte = avm_readdata_i[15:8];
      2'b10:   w_byte = avm_readdata_i[23:16];
      2'b11:   w_byte = avm_readdata_i[31:24];
      default: ;
    endcase
    w_half = r_offset[1] ? avm_readdata_i[31:16] : avm_readdata_i[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_ext = avm_readdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_is_load        <= 1'b0;
      r_signed         <= 1'b0;
      r_size           <= 2'b00;
      r_offset         <= 2'b00;
      r_wait_cnt       <= 32'd0;
      r_bus_err        <= 1'b0;
      load_data_o      <= 32'd0;
      avm_address_o    <= 32'd0;
      avm_writedata_o  <= 32'd0;
      avm_byteenable_o <= 4'b0000;
    end else if (w_accept) begin
      r_is_load  <= is_load_i;
      r_signed   <= signed_i;
      r_size     <= size_i;
      r_offset   <= addr_i[1:0];
      r_wait_cnt <= 32'd0;
      r_bus_err  <= 1'b0;
      if (!w_misaligned) begin
        avm_address_o    <= {addr_i[31:2], 2'b00};
        avm_writedata_o  <= w_wdata;
        avm_byteenable_o <= w_be;
      end
    end else if (r_state == c_ACCESS) begin
      if (avm_waitrequest_i) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
        if (w_timeout) r_bus_err <= 1'b1;
      end else if (r_is_load) begin
        load_data_o <= w_load_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk, reset_i, start_i, is_load_i, signed_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, store_data_i;
  logic        busy_o, done_o, misaligned_o, bus_error_o;
  logic [31:0] load_data_o, avm_address_o, avm_writedata_o;
  logic        avm_read_o, avm_write_o, avm_waitrequest_i;
  logic [3:0]  avm_byteenable_o;
  logic [31:0] avm_readdata_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_load = 32'd0;

  mem_access_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .is_load_i(is_load_i),
    .size_i(size_i), .signed_i(signed_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .busy_o(busy_o), .done_o(done_o),
    .misaligned_o(misaligned_o), .bus_error_o(bus_error_o),
    .load_data_o(load_data_o), .avm_address_o(avm_address_o),
    .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 0; is_load_i = 0; size_i = 0; signed_i = 0;
    addr_i = 0; store_data_i = 0; avm_waitrequest_i = 0; avm_readdata_i = 0;
    #12;
    n_tests++; if ({busy_o, done_o, misaligned_o, bus_error_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {busy_o, done_o, misaligned_o, bus_error_o}); end
    n_tests++; if ({avm_read_o, avm_write_o} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {avm_read_o, avm_write_o}); end
    n_tests++; if (load_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_load_data: got %h want 0", load_data_o); end
    n_tests++; if (avm_address_o !== 32'd0 || avm_writedata_o !== 32'd0 || avm_byteenable_o !== 4'd0) begin n_fail++; $display("FAIL reset_bus_regs: got addr %h wd %h be %b want 0", avm_address_o, avm_writedata_o, avm_byteenable_o); end
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_lw();
    tick();
    start_i = 1; is_load_i = 1; size_i = 2'b10; signed_i = 0; addr_i = 32'h100;
    avm_waitrequest_i = 0; avm_readdata_i = 32'hDEADBEEF;
    tick();
    start_i = 0;
    n_tests++; if ({avm_read_o, avm_write_o, busy_o, done_o} !== 4'b1010) begin n_fail++; $display("FAIL lw_access: got rd/wr/busy/done %b want 1010", {avm_read_o, avm_write_o, busy_o, done_o}); end
    n_tests++; if (avm_address_o !== 32'h100 || avm_byteenable_o !== 4'b1111) begin n_fail++; $display("FAIL lw_addr_be: got %h/%b want 00000100/1111", avm_address_o, avm_byteenable_o); end
    tick();
    n_tests++; if ({done_o, avm_read_o, misaligned_o, bus_error_o, busy_o} !== 5'b10001) begin n_fail++; $display("FAIL lw_done: got done/rd/mis/err/busy %b want 10001", {done_o, avm_read_o, misaligned_o, bus_error_o, busy_o}); end
    n_tests++; if (load_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", load_data_o); end
    last_load = 32'hDEADBEEF;
    tick();
    n_tests++; if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL lw_idle: got busy/done %b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_load_ext();
    logic [31:0] a, rd, exp;
    logic [1:0]  sz;
    logic        sg;
    logic [3:0]  be;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       begin a = 32'h103; sz = 2'b00; sg = 1; rd = 32'h80FF1234; be = 4'b1000; exp = 32'hFFFFFF80; end
        1:       begin a = 32'h103; sz = 2'b00; sg = 0; rd = 32'h80FF1234; be = 4'b1000; exp = 32'h00000080; end
        2:       begin a = 32'h102; sz = 2'b01; sg = 1; rd = 32'h80FF1234; be = 4'b1100; exp = 32'hFFFF80FF; end
        3:       begin a = 32'h100; sz = 2'b01; sg = 0; rd = 32'h80FF8234; be = 4'b0011; exp = 32'h00008234; end
        default: begin a = 32'h101; sz = 2'b00; sg = 1; rd = 32'h0000A500; be = 4'b0010; exp = 32'hFFFFFFA5; end
      endcase
      tick();
      start_i = 1; is_load_i = 1; size_i = sz; signed_i = sg; addr_i = a;
      avm_waitrequest_i = 0; avm_readdata_i = rd;
      tick();
      start_i = 0;
      n_tests++; if (avm_read_o !== 1'b1 || avm_byteenable_o !== be || avm_address_o !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL ld%0d_access: got rd %b be %b addr %h want 1 %b %h", i, avm_read_o, avm_byteenable_o, avm_address_o, be, a & 32'hFFFF_FFFC); end
      tick();
      n_tests++; if (done_o !== 1'b1 || load_data_o !== exp) begin n_fail++; $display("FAIL ld%0d_result: got done %b data %h want 1 %h", i, done_o, load_data_o, exp); end
      last_load = exp;
      tick();
    end
  endtask

  task automatic test_store_stall();
    logic [31:0] a, sd, wd;
    logic [1:0]  sz;
    logic [3:0]  be;
    int          stalls;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'h202; sz = 2'b01; sd = 32'hABCD0000; wd = 32'hABCDABCD; be = 4'b1100; stalls = 3; end
        1:       begin a = 32'h301; sz = 2'b00; sd = 32'h5A000000; wd = 32'h5A5A5A5A; be = 4'b0010; stalls = 1; end
        default: begin a = 32'h000; sz = 2'b10; sd = 32'h12345678; wd = 32'h12345678; be = 4'b1111; stalls = 0; end
      endcase
      tick();
      start_i = 1; is_load_i = 0; size_i = sz; signed_i = 0; addr_i = a;
      store_data_i = sd; avm_readdata_i = 32'h0;
      for (int c = 1; c <= stalls + 1; c++) begin
        tick();
        start_i = 0;
        avm_waitrequest_i = (c <= stalls);
        n_tests++; if ({avm_write_o, avm_read_o, done_o} !== 3'b100 || avm_writedata_o !== wd || avm_byteenable_o !== be || avm_address_o !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL st%0d_cycle%0d: got wr/rd/done %b wd %h be %b addr %h want 100 %h %b %h", i, c, {avm_write_o, avm_read_o, done_o}, avm_writedata_o, avm_byteenable_o, avm_address_o, wd, be, a & 32'hFFFF_FFFC); end
      end
      tick();
      n_tests++; if ({done_o, avm_write_o, bus_error_o} !== 3'b100) begin n_fail++; $display("FAIL st%0d_done: got done/wr/err %b want 100", i, {done_o, avm_write_o, bus_error_o}); end
      n_tests++; if (load_data_o !== last_load) begin n_fail++; $display("FAIL st%0d_load_hold: got %h want %h", i, load_data_o, last_load); end
      tick();
    end
    avm_waitrequest_i = 0;
  endtask

  task automatic test_misaligned();
    logic [31:0] a;
    logic [1:0]  sz;
    logic        ld;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'h101; sz = 2'b10; ld = 1; end
        1:       begin a = 32'h201; sz = 2'b01; ld = 0; end
        default: begin a = 32'h000; sz = 2'b11; ld = 1; end
      endcase
      tick();
      start_i = 1; is_load_i = ld; size_i = sz; addr_i = a; avm_waitrequest_i = 0;
      avm_readdata_i = 32'h55555555;
      tick();
      start_i = 0;
      n_tests++; if ({busy_o, done_o, misaligned_o, bus_error_o, avm_read_o, avm_write_o} !== 6'b111000) begin n_fail++; $display("FAIL mis%0d_pulse: got busy/done/mis/err/rd/wr %b want 111000", i, {busy_o, done_o, misaligned_o, bus_error_o, avm_read_o, avm_write_o}); end
      tick();
      n_tests++; if ({busy_o, done_o, misaligned_o, avm_read_o, avm_write_o} !== 5'b00000 || load_data_o !== last_load) begin n_fail++; $display("FAIL mis%0d_after: got flags %b data %h want 00000 %h", i, {busy_o, done_o, misaligned_o, avm_read_o, avm_write_o}, load_data_o, last_load); end
    end
  endtask

  task automatic test_timeout();
    tick();
    start_i = 1; is_load_i = 0; size_i = 2'b10; addr_i = 32'h400;
    store_data_i = 32'h11223344; avm_waitrequest_i = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start_i = 0;
      n_tests++; if ({avm_write_o, done_o, bus_error_o} !== 3'b100 || avm_writedata_o !== 32'h11223344) begin n_fail++; $display("FAIL to_cycle%0d: got wr/done/err %b wd %h want 100 11223344", c, {avm_write_o, done_o, bus_error_o}, avm_writedata_o); end
    end
    tick();
    n_tests++; if ({done_o, bus_error_o, avm_write_o, misaligned_o} !== 4'b1100) begin n_fail++; $display("FAIL to_done: got done/err/wr/mis %b want 1100", {done_o, bus_error_o, avm_write_o, misaligned_o}); end
    tick();
    start_i = 1; addr_i = 32'h404; store_data_i = 32'hA5A5A5A5; avm_waitrequest_i = 0;
    n_tests++; if ({busy_o, bus_error_o} !== 2'b00) begin n_fail++; $display("FAIL to_idle: got busy/err %b want 00", {busy_o, bus_error_o}); end
    tick();
    start_i = 0;
    n_tests++; if (avm_write_o !== 1'b1 || avm_address_o !== 32'h404) begin n_fail++; $display("FAIL to_restart: got wr %b addr %h want 1 00000404", avm_write_o, avm_address_o); end
    tick();
    n_tests++; if ({done_o, bus_error_o} !== 2'b10) begin n_fail++; $display("FAIL to_restart_done: got done/err %b want 10", {done_o, bus_error_o}); end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    start_i = 1; is_load_i = 1; size_i = 2'b10; signed_i = 0; addr_i = 32'h500;
    avm_waitrequest_i = 1; avm_readdata_i = 32'h0;
    tick();
    start_i = 0;
    tick();
    n_tests++; if (avm_read_o !== 1'b1) begin n_fail++; $display("FAIL rst_stalled_read: got %b want 1", avm_read_o); end
    #2 reset_i = 1'b1;
    #1;
    n_tests++; if ({avm_read_o, avm_write_o, busy_o, done_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_async_drop: got rd/wr/busy/done %b want 0000", {avm_read_o, avm_write_o, busy_o, done_o}); end
    n_tests++; if (load_data_o !== 32'd0 || avm_address_o !== 32'd0 || avm_byteenable_o !== 4'd0 || avm_writedata_o !== 32'd0) begin n_fail++; $display("FAIL rst_async_regs: got data %h addr %h be %b wd %h want 0", load_data_o, avm_address_o, avm_byteenable_o, avm_writedata_o); end
    last_load = 32'd0;
    @(negedge clk);
    reset_i = 1'b0; avm_waitrequest_i = 0;
    tick();
    start_i = 1; addr_i = 32'h104; avm_readdata_i = 32'hCAFEF00D;
    tick();
    addr_i = 32'h108;
    n_tests++; if (avm_read_o !== 1'b1 || avm_address_o !== 32'h104) begin n_fail++; $display("FAIL rst_next_access: got rd %b addr %h want 1 00000104", avm_read_o, avm_address_o); end
    tick();
    n_tests++; if (done_o !== 1'b1 || load_data_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_next_done: got done %b data %h want 1 cafef00d", done_o, load_data_o); end
    tick();
    start_i = 0;
    n_tests++; if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL busy_start_ignored: got busy/done %b want 00", {busy_o, done_o}); end
    tick();
    n_tests++; if ({busy_o, avm_read_o} !== 2'b00) begin n_fail++; $display("FAIL busy_start_idle: got busy/rd %b want 00", {busy_o, avm_read_o}); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_stall();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
